// File: rtl/clock_time_keeper_pkg.sv
// clock_time_keeper_pkg: shared BCD time types, keypad constants and HH:MM validity check
package clock_time_keeper_pkg;
  localparam logic [3:0] NO_KEY = 4'd10;
  typedef logic [3:0] bcd_t;
  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
  } hhmm_t;
  function automatic logic hhmm_valid(hhmm_t t);
    return ((t.h1 < 4'd2 && t.h0 <= 4'd9) || (t.h1 == 4'd2 && t.h0 <= 4'd3)) && t.m1 <= 4'd5 && t.m0 <= 4'd9;
  endfunction
endpackage

// File: rtl/clock_time_keeper_bcd_hhmm_counter.sv
// bcd_hhmm_counter: loadable 24-hour BCD HH:MM counter, load wins over advance
module bcd_hhmm_counter
  import clock_time_keeper_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_adv,
  input  logic  i_load,
  input  hhmm_t i_d,
  output hhmm_t o_q
);
  hhmm_t r_q;
  hhmm_t w_nxt;
  logic  w_c_m0;
  logic  w_c_m1;
  assign w_c_m0 = r_q.m0 == 4'd9;
  assign w_c_m1 = w_c_m0 && r_q.m1 == 4'd5;
  // next minute value with BCD carries and 23:59 rollover
  always_comb begin
    w_nxt.m0 = w_c_m0 ? 4'd0 : r_q.m0 + 4'd1;
    w_nxt.m1 = w_c_m1 ? 4'd0 : w_c_m0 ? r_q.m1 + 4'd1 : r_q.m1;
    w_nxt.h1 = !w_c_m1 ? r_q.h1 : (r_q.h1 == 4'd2 && r_q.h0 == 4'd3) ? 4'd0 : r_q.h0 == 4'd9 ? r_q.h1 + 4'd1 : r_q.h1;
    w_nxt.h0 = !w_c_m1 ? r_q.h0 : (r_q.h1 == 4'd2 && r_q.h0 == 4'd3) || r_q.h0 == 4'd9 ? 4'd0 : r_q.h0 + 4'd1;
  end
  // time register update
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_adv) r_q <= w_nxt;
  assign o_q = r_q;
endmodule

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: key-entry buffer, alarm register, running time, display mux and alarm detect
module clock_time_keeper
  import clock_time_keeper_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int SEC_W         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       shift,
  input  logic       load_new_a,
  input  logic       load_new_c,
  input  logic       reset_count,
  input  logic       show_a,
  input  logic       show_new_time,
  input  logic       alarm_on,
  input  logic       stop_alarm,
  output logic [3:0] disp_h1,
  output logic [3:0] disp_h0,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_m0,
  output logic       alarm_sound
);
  hhmm_t            r_buf;
  hhmm_t            r_alarm;
  hhmm_t            w_time;
  hhmm_t            w_disp;
  logic [SEC_W-1:0] r_sec;
  logic             r_match_q;
  logic             w_valid;
  logic             w_wrap;
  logic             w_adv;
  logic             w_match;
  assign w_valid = hhmm_valid(r_buf);
  assign w_wrap  = r_sec == SEC_W'(TICKS_PER_MIN - 1);
  assign w_adv   = one_second && !reset_count && w_wrap;
  assign w_match = alarm_on && w_time == r_alarm;
  // entry buffer: shift in digits, clear after any load attempt
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_buf <= '0;
    else if (load_new_a || load_new_c) r_buf <= '0;
    else if (shift && key <= 4'd9) r_buf <= {r_buf.h0, r_buf.m1, r_buf.m0, key};
  // alarm register takes only valid times
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_alarm <= '0;
    else if (load_new_a && w_valid) r_alarm <= r_buf;
  // seconds counter, cleared by reset_count ahead of any tick
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sec <= '0;
    else if (reset_count) r_sec <= '0;
    else if (one_second) r_sec <= w_wrap ? '0 : r_sec + 1'b1;
  bcd_hhmm_counter u_time (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (w_adv),
    .i_load (load_new_c && w_valid),
    .i_d    (r_buf),
    .o_q    (w_time)
  );
  // alarm fires on the rising edge of match; match_q starts high to mask the reset coincidence
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_match_q   <= 1'b1;
      alarm_sound <= 1'b0;
    end else begin
      r_match_q   <= w_match;
      alarm_sound <= (stop_alarm || !alarm_on) ? 1'b0 : (w_match && !r_match_q) ? 1'b1 : alarm_sound;
    end
  assign w_disp = show_a ? r_alarm : show_new_time ? r_buf : w_time;
  assign {disp_h1, disp_h0, disp_m1, disp_m0} = w_disp;
endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper: directed self-checking bench for clock_time_keeper
module tb_clock_time_keeper;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd10;
  logic       shift = 1'b0;
  logic       load_new_a = 1'b0;
  logic       load_new_c = 1'b0;
  logic       reset_count = 1'b0;
  logic       show_a = 1'b0;
  logic       show_new_time = 1'b0;
  logic       alarm_on = 1'b0;
  logic       stop_alarm = 1'b0;
  logic [3:0] disp_h1, disp_h0, disp_m1, disp_m0;
  logic       alarm_sound;
  int         checks = 0;
  int         failures = 0;
  int         hits;
  wire [15:0] disp = {disp_h1, disp_h0, disp_m1, disp_m0};

  clock_time_keeper #(.TICKS_PER_MIN(4), .SEC_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .reset_count   (reset_count),
    .show_a        (show_a),
    .show_new_time (show_new_time),
    .alarm_on      (alarm_on),
    .stop_alarm    (stop_alarm),
    .disp_h1       (disp_h1),
    .disp_h0       (disp_h0),
    .disp_m1       (disp_m1),
    .disp_m0       (disp_m0),
    .alarm_sound   (alarm_sound)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic enter(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      shift = 1'b1;
      key = v[i*4 +: 4];
      cyc();
    end
    shift = 1'b0;
    key = 4'd10;
  endtask

  task automatic loadc();
    load_new_c = 1'b1;
    reset_count = 1'b1;
    cyc();
    load_new_c = 1'b0;
    reset_count = 1'b0;
  endtask

  task automatic loada();
    load_new_a = 1'b1;
    cyc();
    load_new_a = 1'b0;
  endtask

  task automatic tick();
    one_second = 1'b1;
    cyc();
    one_second = 1'b0;
    cyc();
  endtask

  initial begin
    alarm_on = 1'b1;
    repeat (3) cyc();
    chk("reset_disp", disp, 16'h0000);
    chk("reset_alarm", {15'd0, alarm_sound}, 16'h0000);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (alarm_sound) hits++;
    end
    chk("no_spurious_alarm", 16'(hits), 16'h0000);
    chk("idle_disp", disp, 16'h0000);
    alarm_on = 1'b0;

    enter(16'h1234);
    show_new_time = 1'b1;
    #1;
    chk("buf_1234", disp, 16'h1234);
    show_new_time = 1'b0;
    loadc();
    chk("time_1234", disp, 16'h1234);
    show_new_time = 1'b1;
    #1;
    chk("buf_cleared", disp, 16'h0000);
    shift = 1'b1;
    key = 4'd10;
    cyc();
    shift = 1'b0;
    chk("no_key_shift", disp, 16'h0000);
    show_new_time = 1'b0;

    enter(16'h2359);
    loadc();
    repeat (3) tick();
    chk("2359_hold", disp, 16'h2359);
    tick();
    chk("2359_wrap", disp, 16'h0000);
    enter(16'h0959);
    loadc();
    repeat (4) tick();
    chk("0959_adv", disp, 16'h1000);
    enter(16'h1959);
    loadc();
    repeat (4) tick();
    chk("1959_adv", disp, 16'h2000);

    enter(16'h2400);
    loada();
    show_a = 1'b1;
    #1;
    chk("alarm_invalid", disp, 16'h0000);
    show_a = 1'b0;
    show_new_time = 1'b1;
    #1;
    chk("buf_clr_invalid", disp, 16'h0000);
    show_new_time = 1'b0;
    enter(16'h0760);
    loadc();
    chk("time_invalid", disp, 16'h2000);

    enter(16'h0701);
    loada();
    enter(16'h0700);
    loadc();
    alarm_on = 1'b1;
    repeat (3) tick();
    chk("pre_alarm_disp", disp, 16'h0700);
    chk("pre_alarm_snd", {15'd0, alarm_sound}, 16'h0000);
    one_second = 1'b1;
    cyc();
    one_second = 1'b0;
    chk("alarm_time_disp", disp, 16'h0701);
    chk("alarm_not_yet", {15'd0, alarm_sound}, 16'h0000);
    cyc();
    chk("alarm_fires", {15'd0, alarm_sound}, 16'h0001);
    repeat (3) cyc();
    chk("alarm_holds", {15'd0, alarm_sound}, 16'h0001);
    stop_alarm = 1'b1;
    cyc();
    stop_alarm = 1'b0;
    chk("alarm_stopped", {15'd0, alarm_sound}, 16'h0000);
    repeat (2) tick();
    chk("alarm_stays_off", {15'd0, alarm_sound}, 16'h0000);

    show_a = 1'b1;
    show_new_time = 1'b1;
    #1;
    chk("show_a_priority", disp, 16'h0701);
    show_a = 1'b0;
    show_new_time = 1'b0;

    enter(16'h0700);
    loadc();
    repeat (3) tick();
    one_second = 1'b1;
    cyc();
    one_second = 1'b0;
    chk("edge2_disp", disp, 16'h0701);
    stop_alarm = 1'b1;
    cyc();
    stop_alarm = 1'b0;
    chk("stop_on_edge", {15'd0, alarm_sound}, 16'h0000);
    cyc();
    chk("stop_on_edge_after", {15'd0, alarm_sound}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
